// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray conversion and the default pointer type.
// Used by both the read- and write-side controllers.
package fifo_pkg;

  // The converters work on a fixed wide vector. A narrower pointer is
  // zero-extended on the way in and truncated on the way out. Zero upper bits
  // do not change the result for either conversion, so one function covers
  // every pointer width up to MaxPtrW.
  localparam int unsigned MaxPtrW      = 32;
  localparam int unsigned DefAddrWidth = 8;

  typedef logic [DefAddrWidth:0] ptr_t;

  function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] gray);
    logic [MaxPtrW-1:0] bin;
    bin[MaxPtrW-1] = gray[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO, in the rd_clk domain.
// It owns the read pointer in binary and Gray form. From the synchronised Gray
// write pointer it derives empty, almost_empty, the fill level and a sticky
// underflow flag.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned Addr_Width = 8,
  parameter int unsigned AE_Thresh  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic [Addr_Width:0]   wr_ptr_sync,
  input  logic                  rd_en,
  input  logic                  underflow_clr,
  output logic [Addr_Width-1:0] rd_addr,
  output logic [Addr_Width:0]   rd_ptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [Addr_Width:0]   rd_level,
  output logic                  underflow
);

  typedef logic [Addr_Width:0] lptr_t;

  localparam lptr_t AeThresh = lptr_t'(AE_Thresh);

  lptr_t rd_bin_q,   rd_bin_d;
  lptr_t rd_gray_q,  rd_gray_d;
  lptr_t rd_level_q, rd_level_d;
  logic  empty_q,    empty_d;
  logic  ae_q,       ae_d;
  logic  uflow_q,    uflow_d;
  logic  rd_fire;
  lptr_t wr_bin;

  // Next pointer and flags. The flags use the post-pop pointer and the current
  // write pointer, so a simultaneous pop and write is accounted in one edge.
  always_comb begin
    rd_fire    = rd_en & ~empty_q;
    rd_bin_d   = rd_bin_q + lptr_t'(rd_fire);
    rd_gray_d  = lptr_t'(bin2gray(MaxPtrW'(rd_bin_d)));
    wr_bin     = lptr_t'(gray2bin(MaxPtrW'(wr_ptr_sync)));
    rd_level_d = wr_bin - rd_bin_d;
    empty_d    = (rd_gray_d == wr_ptr_sync);
    ae_d       = (rd_level_d <= AeThresh);
    // Setting the flag takes priority over clearing it in the same cycle.
    uflow_d    = (rd_en & empty_q) | (uflow_q & ~underflow_clr);
  end

  // Pointer and status registers. Reset forces the empty state at once.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      rd_level_q <= '0;
      empty_q    <= 1'b1;
      ae_q       <= 1'b1;
      uflow_q    <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      rd_level_q <= rd_level_d;
      empty_q    <= empty_d;
      ae_q       <= ae_d;
      uflow_q    <= uflow_d;
    end
  end

  assign rd_addr      = rd_bin_q[Addr_Width-1:0];
  assign rd_ptr       = rd_gray_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = rd_level_q;
  assign underflow    = uflow_q;

endmodule
